// File: rtl/ai_player_pkg.sv
// Shared definitions for the AI move generator: cell codes, turn encoding,
// FSM state encoding and common width types.
package ai_player_pkg;

    localparam logic [1:0] CELL_BLANK = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;

    localparam logic TURN_AI     = 1'b1;
    localparam logic TURN_PLAYER = 1'b0;

    typedef logic [2:0] state_t;
    typedef logic       flag_t;
    typedef logic [1:0] cell_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_SCAN   = 3'd2;
    localparam state_t ST_SUBMIT = 3'd3;
    localparam state_t ST_RESET  = 3'd4;
    localparam state_t ST_DONE   = 3'd5;

    // Width of an index able to address n distinct values (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ai_player_line_checker.sv
// Combinational test: would placing a mark at (r, c) complete its row, column
// or either diagonal, given the other N-1 cells of that line in the snapshot.
module ai_player_line_checker
    import ai_player_pkg::*;
#(
    parameter int BOARD_DIM = 3,
    parameter int RC_W      = idx_width(BOARD_DIM)
) (
    input  logic [2*BOARD_DIM*BOARD_DIM-1:0] snap,
    input  logic [RC_W-1:0]                  r,
    input  logic [RC_W-1:0]                  c,
    input  cell_t                            mark,
    output logic                             completes_line
);

    logic row_ok;
    logic col_ok;
    logic diag_ok;
    logic anti_ok;
    int   ri;
    int   ci;

    // The cell at (r, c) itself is excluded from every line it belongs to.
    always_comb begin
        ri      = int'(r);
        ci      = int'(c);
        row_ok  = 1'b1;
        col_ok  = 1'b1;
        diag_ok = (ri == ci);
        anti_ok = (ri + ci == BOARD_DIM - 1);
        for (int j = 0; j < BOARD_DIM; j++) begin
            if (j != ci && snap[2*(ri*BOARD_DIM + j) +: 2] != mark) begin
                row_ok = 1'b0;
            end
            if (j != ri && snap[2*(j*BOARD_DIM + ci) +: 2] != mark) begin
                col_ok = 1'b0;
            end
            if (j != ri && snap[2*(j*BOARD_DIM + j) +: 2] != mark) begin
                diag_ok = 1'b0;
            end
            if (j != ri && snap[2*(j*BOARD_DIM + BOARD_DIM - 1 - j) +: 2] != mark) begin
                anti_ok = 1'b0;
            end
        end
        completes_line = row_ok | col_ok | diag_ok | anti_ok;
    end

endmodule

// File: rtl/ai_player.sv
// Clocked AI move generator: snapshots the board on its turn, scans one cell
// per cycle and then issues exactly one submit or board-reset request.
module ai_player
    import ai_player_pkg::*;
#(
    parameter int          BOARD_DIM = 3,
    parameter int          STRATEGY  = 1,
    parameter logic [1:0]  AI_MARK   = CELL_O,
    parameter logic [1:0]  OPP_MARK  = CELL_X,
    localparam int         CELLS     = BOARD_DIM * BOARD_DIM,
    localparam int         IDX_W     = idx_width(CELLS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2*CELLS-1:0]   board_state,
    input  logic                 turn,
    output logic [IDX_W-1:0]     update_loc,
    output logic [1:0]           update_val,
    output logic                 submit,
    output logic                 reset,
    output logic                 busy
);

    localparam int RC_W = idx_width(BOARD_DIM);
    localparam logic USE_RULES = (STRATEGY == 1);

    typedef logic [IDX_W-1:0] index_t;
    typedef logic [RC_W-1:0]  rc_t;

    localparam index_t LAST_IDX = index_t'(CELLS - 1);
    localparam rc_t    LAST_RC  = rc_t'(BOARD_DIM - 1);

    state_t             state_q, state_d;
    logic [2*CELLS-1:0] snap_q, snap_d;
    index_t             cnt_q, cnt_d;
    rc_t                r_q, r_d;
    rc_t                c_q, c_d;
    flag_t              win_found_q, win_found_d;
    flag_t              block_found_q, block_found_d;
    flag_t              free_found_q, free_found_d;
    index_t             win_idx_q, win_idx_d;
    index_t             block_idx_q, block_idx_d;
    index_t             free_idx_q, free_idx_d;
    index_t             update_loc_q, update_loc_d;
    logic               submit_q, submit_d;
    logic               reset_q, reset_d;

    cell_t              cur_cell;
    logic               cur_blank;
    logic               win_hit;
    logic               block_hit;

    assign cur_cell  = snap_q[2*cnt_q +: 2];
    assign cur_blank = (cur_cell == CELL_BLANK);

    ai_player_line_checker #(
        .BOARD_DIM (BOARD_DIM),
        .RC_W      (RC_W)
    ) u_win_check (
        .snap           (snap_q),
        .r              (r_q),
        .c              (c_q),
        .mark           (AI_MARK),
        .completes_line (win_hit)
    );

    ai_player_line_checker #(
        .BOARD_DIM (BOARD_DIM),
        .RC_W      (RC_W)
    ) u_block_check (
        .snap           (snap_q),
        .r              (r_q),
        .c              (c_q),
        .mark           (OPP_MARK),
        .completes_line (block_hit)
    );

    // Next-state logic; the final scan cycle folds its own findings into the
    // move choice so the strobe can follow on the very next edge.
    always_comb begin
        state_d       = state_q;
        snap_d        = snap_q;
        cnt_d         = cnt_q;
        r_d           = r_q;
        c_d           = c_q;
        win_found_d   = win_found_q;
        block_found_d = block_found_q;
        free_found_d  = free_found_q;
        win_idx_d     = win_idx_q;
        block_idx_d   = block_idx_q;
        free_idx_d    = free_idx_q;
        update_loc_d  = update_loc_q;
        submit_d      = 1'b0;
        reset_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (turn == TURN_AI) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (turn == TURN_PLAYER) begin
                    state_d = ST_IDLE;
                end else begin
                    snap_d        = board_state;
                    cnt_d         = '0;
                    r_d           = '0;
                    c_d           = '0;
                    win_found_d   = 1'b0;
                    block_found_d = 1'b0;
                    free_found_d  = 1'b0;
                    state_d       = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (turn == TURN_PLAYER) begin
                    state_d = ST_IDLE;
                end else begin
                    if (cur_blank && !free_found_q) begin
                        free_found_d = 1'b1;
                        free_idx_d   = cnt_q;
                    end
                    if (USE_RULES && cur_blank && win_hit && !win_found_q) begin
                        win_found_d = 1'b1;
                        win_idx_d   = cnt_q;
                    end
                    if (USE_RULES && cur_blank && block_hit && !block_found_q) begin
                        block_found_d = 1'b1;
                        block_idx_d   = cnt_q;
                    end

                    if (cnt_q == LAST_IDX) begin
                        if (win_found_d) begin
                            update_loc_d = win_idx_d;
                        end else if (block_found_d) begin
                            update_loc_d = block_idx_d;
                        end else begin
                            update_loc_d = free_idx_d;
                        end
                        if (win_found_d || block_found_d || free_found_d) begin
                            submit_d = 1'b1;
                            state_d  = ST_SUBMIT;
                        end else begin
                            reset_d = 1'b1;
                            state_d = ST_RESET;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (c_q == LAST_RC) begin
                            c_d = '0;
                            r_d = r_q + 1'b1;
                        end else begin
                            c_d = c_q + 1'b1;
                        end
                    end
                end
            end
            ST_SUBMIT: state_d = ST_DONE;
            ST_RESET:  state_d = ST_DONE;
            ST_DONE: begin
                if (turn == TURN_PLAYER) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            snap_q        <= '0;
            cnt_q         <= '0;
            r_q           <= '0;
            c_q           <= '0;
            win_found_q   <= 1'b0;
            block_found_q <= 1'b0;
            free_found_q  <= 1'b0;
            win_idx_q     <= '0;
            block_idx_q   <= '0;
            free_idx_q    <= '0;
            update_loc_q  <= '0;
            submit_q      <= 1'b0;
            reset_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            snap_q        <= snap_d;
            cnt_q         <= cnt_d;
            r_q           <= r_d;
            c_q           <= c_d;
            win_found_q   <= win_found_d;
            block_found_q <= block_found_d;
            free_found_q  <= free_found_d;
            win_idx_q     <= win_idx_d;
            block_idx_q   <= block_idx_d;
            free_idx_q    <= free_idx_d;
            update_loc_q  <= update_loc_d;
            submit_q      <= submit_d;
            reset_q       <= reset_d;
        end
    end

    assign busy = (state_q == ST_START) || (state_q == ST_SCAN) ||
                  (state_q == ST_SUBMIT) || (state_q == ST_RESET);

    // The bus is shared with the player block, so release it on its turn.
    assign update_loc = (turn == TURN_AI) ? update_loc_q : {IDX_W{1'bz}};
    assign update_val = (turn == TURN_AI) ? AI_MARK      : 2'bzz;
    assign submit     = (turn == TURN_AI) ? submit_q     : 1'bz;
    assign reset      = (turn == TURN_AI) ? reset_q      : 1'bz;

endmodule

// File: tb/tb_ai_player.sv
// Self-checking bench for ai_player: directed turns plus randomized boards
// compared against a rule-level move model.
module tb_ai_player;

    logic        clk;
    logic        rst_n;
    logic [17:0] board3;
    logic [31:0] board4;
    logic        turn0, turn1, turn4;

    // Pulled-up bus nets: a released pin reads as all ones.
    tri1 [3:0] loc0, loc1, loc4;
    tri1 [1:0] val0, val1, val4;
    tri1       sub0, sub1, sub4;
    tri1       rst0, rst1, rst4;
    wire       busy0, busy1, busy4;

    int          sel;
    logic [3:0]  o_loc;
    logic [1:0]  o_val;
    logic        o_sub, o_rst, o_busy;

    int tests;
    int failures;

    ai_player #(.BOARD_DIM(3), .STRATEGY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .board_state(board3), .turn(turn0),
        .update_loc(loc0), .update_val(val0), .submit(sub0), .reset(rst0), .busy(busy0));

    ai_player #(.BOARD_DIM(3), .STRATEGY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .board_state(board3), .turn(turn1),
        .update_loc(loc1), .update_val(val1), .submit(sub1), .reset(rst1), .busy(busy1));

    ai_player #(.BOARD_DIM(4), .STRATEGY(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .board_state(board4), .turn(turn4),
        .update_loc(loc4), .update_val(val4), .submit(sub4), .reset(rst4), .busy(busy4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (sel)
            1:       begin o_loc = loc1; o_val = val1; o_sub = sub1; o_rst = rst1; o_busy = busy1; end
            2:       begin o_loc = loc4; o_val = val4; o_sub = sub4; o_rst = rst4; o_busy = busy4; end
            default: begin o_loc = loc0; o_val = val0; o_sub = sub0; o_rst = rst0; o_busy = busy0; end
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic setTurn(input int which, input logic v);
        case (which)
            1:       turn1 = v;
            2:       turn4 = v;
            default: turn0 = v;
        endcase
    endtask

    function automatic logic [1:0] cellOf(input logic [31:0] brd, input int k);
        return brd[2*k +: 2];
    endfunction

    // True when every other cell of some line through k holds mark.
    function automatic bit wouldComplete(input logic [31:0] brd, input int n, input int k,
                                         input logic [1:0] mark);
        int  r, c;
        bit  ok;
        r = k / n;
        c = k % n;
        ok = 1;
        for (int j = 0; j < n; j++) if (j != c && cellOf(brd, r*n + j) != mark) ok = 0;
        if (ok) return 1;
        ok = 1;
        for (int i = 0; i < n; i++) if (i != r && cellOf(brd, i*n + c) != mark) ok = 0;
        if (ok) return 1;
        if (r == c) begin
            ok = 1;
            for (int i = 0; i < n; i++) if (i != r && cellOf(brd, i*n + i) != mark) ok = 0;
            if (ok) return 1;
        end
        if (r + c == n - 1) begin
            ok = 1;
            for (int i = 0; i < n; i++) if (i != r && cellOf(brd, i*n + (n-1-i)) != mark) ok = 0;
            if (ok) return 1;
        end
        return 0;
    endfunction

    function automatic void modelMove(input logic [31:0] brd, input int n, input int strat,
                                      output int is_reset, output int loc);
        int first_free, win, blk;
        first_free = -1; win = -1; blk = -1;
        for (int k = 0; k < n*n; k++) begin
            if (cellOf(brd, k) == 2'b00) begin
                if (first_free < 0) first_free = k;
                if (strat == 1 && win < 0 && wouldComplete(brd, n, k, 2'b10)) win = k;
                if (strat == 1 && blk < 0 && wouldComplete(brd, n, k, 2'b01)) blk = k;
            end
        end
        is_reset = 0;
        if (win >= 0)             loc = win;
        else if (blk >= 0)        loc = blk;
        else if (first_free >= 0) loc = first_free;
        else begin
            loc = 0;
            is_reset = 1;
        end
    endfunction

    function automatic logic [31:0] packBoard(input int v[16]);
        logic [31:0] b;
        b = '0;
        for (int k = 0; k < 16; k++) b[2*k +: 2] = 2'(v[k]);
        return b;
    endfunction

    // One complete AI turn: raise turn, time the strobe, check the move,
    // confirm no repeat while turn is held, then release the bus.
    task automatic applyStimulus(input string tag, input int which, input logic [31:0] brd,
                                 input int exp_reset, input int exp_loc, input int hold);
        int n, cycles, extra;
        bit hit;
        n = (which == 2) ? 4 : 3;
        sel = which;
        if (which == 2) board4 = brd;
        else            board3 = brd[17:0];
        setTurn(which, 1'b1);
        cycles = 0;
        hit = 0;
        while (!hit && cycles < 60) begin
            @(posedge clk); #1;
            cycles++;
            if (o_sub === 1'b1 || o_rst === 1'b1) hit = 1;
        end
        checkOutput({tag, "_latency"}, cycles, n*n + 2);
        if (hit) begin
            checkOutput({tag, "_reset"}, {31'd0, o_rst}, exp_reset);
            checkOutput({tag, "_submit"}, {31'd0, o_sub}, (exp_reset != 0) ? 0 : 1);
            checkOutput({tag, "_busy"}, {31'd0, o_busy}, 1);
            if (exp_reset == 0) begin
                checkOutput({tag, "_loc"}, {28'd0, o_loc}, exp_loc);
                checkOutput({tag, "_val"}, {30'd0, o_val}, 2);
            end
        end
        @(posedge clk); #1;
        checkOutput({tag, "_strobe_off"}, {30'd0, o_sub, o_rst}, 0);
        checkOutput({tag, "_done_busy"}, {31'd0, o_busy}, 0);
        if (exp_reset == 0) checkOutput({tag, "_loc_hold"}, {28'd0, o_loc}, exp_loc);
        extra = 0;
        repeat (hold) begin
            @(posedge clk); #1;
            if (o_sub === 1'b1 || o_rst === 1'b1) extra++;
        end
        checkOutput({tag, "_single"}, extra, 0);
        setTurn(which, 1'b0);
        #1;
        checkOutput({tag, "_released"}, {24'd0, o_loc, o_val, o_sub, o_rst}, 32'hFF);
        @(posedge clk); #1;
    endtask

    task automatic randomTurn(input string tag, input int which, input int strat);
        int n, er, el;
        logic [31:0] b;
        int cells[16];
        n = (which == 2) ? 4 : 3;
        for (int k = 0; k < 16; k++) begin
            int v;
            v = $urandom_range(0, 5);
            cells[k] = (k >= n*n || v < 3) ? 0 : (v == 3 ? 1 : 2);
        end
        b = packBoard(cells);
        modelMove(b, n, strat, er, el);
        applyStimulus(tag, which, b, er, el, 2);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int cells[16];
        logic [31:0] b;
        tests = 0;
        failures = 0;
        sel = 0;
        rst_n = 1'b0;
        board3 = '0;
        board4 = '0;
        turn0 = 1'b0; turn1 = 1'b0; turn4 = 1'b0;

        #12;
        checkOutput("rst_busy", {31'd0, o_busy}, 0);
        checkOutput("rst_pins_released", {24'd0, o_loc, o_val, o_sub, o_rst}, 32'hFF);
        turn0 = 1'b1;
        #1;
        checkOutput("rst_pins_driven", {24'd0, o_loc, o_val, o_sub, o_rst}, 32'h08);
        turn0 = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus("empty_s0", 0, 32'd0, 0, 0, 30);

        cells = '{2,2,0,1,1,0,0,0,0, 0,0,0,0,0,0,0};
        applyStimulus("win", 1, packBoard(cells), 0, 2, 3);

        cells = '{1,2,0,0,1,0,0,0,0, 0,0,0,0,0,0,0};
        b = packBoard(cells);
        applyStimulus("block", 1, b, 0, 8, 3);
        applyStimulus("block_s0", 0, b, 0, 2, 3);

        cells = '{1,2,1,1,2,2,2,1,1, 0,0,0,0,0,0,0};
        b = packBoard(cells);
        applyStimulus("full_s1", 1, b, 1, 0, 5);
        applyStimulus("full_s0", 0, b, 1, 0, 5);

        // Abort: drop turn part way through the scan.
        sel = 1;
        board3 = '0;
        turn1 = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        checkOutput("abort_busy_before", {31'd0, o_busy}, 1);
        turn1 = 1'b0;
        @(posedge clk); #1;
        checkOutput("abort_idle", {31'd0, o_busy}, 0);
        repeat (15) @(posedge clk);
        #1;
        applyStimulus("after_abort", 1, 32'd0, 0, 0, 3);

        // Asynchronous reset in the middle of a scan.
        sel = 1;
        turn1 = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_busy", {31'd0, o_busy}, 0);
        checkOutput("async_pins", {24'd0, o_loc, o_val, o_sub, o_rst}, 32'h08);
        turn1 = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        cells = '{1,2,0,0,1,0,0,0,0, 0,0,0,0,0,0,0};
        applyStimulus("after_reset", 1, packBoard(cells), 0, 8, 3);

        cells = '{0,0,0,0, 0,0,0,0, 0,0,0,0, 2,2,2,0};
        applyStimulus("dim4_win", 2, packBoard(cells), 0, 15, 3);

        for (int i = 0; i < 12; i++) randomTurn("rand_s1", 1, 1);
        for (int i = 0; i < 8; i++)  randomTurn("rand_s0", 0, 0);
        for (int i = 0; i < 8; i++)  randomTurn("rand_dim4", 2, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
